// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM bridge port between two requesters.
// One access is in flight at a time, and a watchdog ends any access the bridge never acknowledges.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byte_enable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_write_data,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_W-1:0]     m0_read_data,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byte_enable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_write_data,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_W-1:0]     m1_read_data,
    output logic [ADDR_W-1:0]     sdram_address,
    output logic [DATA_W/8-1:0]   sdram_byte_enable,
    output logic                  sdram_read,
    output logic                  sdram_write,
    output logic [DATA_W-1:0]     sdram_write_data,
    input  logic                  sdram_acknowledge,
    input  logic [DATA_W-1:0]     sdram_read_data
);
    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [1:0]              ack_q, ack_d;
    logic [1:0]              err_q, err_d;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

    logic              m0_act, m1_act, pick, pick_write, timeout_hit, finish;
    logic [DATA_W-1:0] resp_data;

    assign m0_act = m0_read | m0_write;
    assign m1_act = m1_read | m1_write;
    // On a contest the master that did not win last time is served.
    assign pick        = (m0_act && m1_act) ? ~last_grant_q : m1_act;
    assign pick_write  = pick ? m1_write : m0_write;
    assign timeout_hit = (TIMEOUT != 0) && (wd_q == WD_LIMIT);
    assign finish      = (state_q == BUSY) && (sdram_acknowledge || timeout_hit);
    assign resp_data   = (sdram_acknowledge && rd_q) ? sdram_read_data : '0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign ack_d[gi]   = finish && (last_grant_q == 1'(gi));
        assign err_d[gi]   = ack_d[gi] && !sdram_acknowledge;
        assign rdata_d[gi] = ack_d[gi] ? resp_data : '0;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wd_d         = '0;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        unique case (state_q)
            IDLE: begin
                if (m0_act || m1_act) begin
                    last_grant_d = pick;
                    addr_d       = pick ? m1_address : m0_address;
                    be_d         = pick_write ? (pick ? m1_byte_enable : m0_byte_enable) : '1;
                    wdata_d      = pick_write ? (pick ? m1_write_data : m0_write_data) : '0;
                    rd_d         = ~pick_write;
                    wr_d         = pick_write;
                    wd_d         = WD_W'(1);
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (finish) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            // Guard cycle: the requester drops its strobe here, so it is never re-granted.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wd_q         <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign sdram_address     = addr_q;
    assign sdram_byte_enable = be_q;
    assign sdram_write_data  = wdata_q;
    assign sdram_read        = rd_q;
    assign sdram_write       = wr_q;
    assign m0_ack            = ack_q[0];
    assign m1_ack            = ack_q[1];
    assign m0_err            = err_q[0];
    assign m1_err            = err_q[1];
    assign m0_read_data      = rdata_q[0];
    assign m1_read_data      = rdata_q[1];
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed scenarios followed by randomized traffic against a transaction-level
// model of the arbiter (who is served, with what, and when the response appears).
module tb_sdram_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] m0_address, m1_address, sdram_address;
    logic [BW-1:0] m0_byte_enable, m1_byte_enable, sdram_byte_enable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_write_data, m1_write_data, m0_read_data, m1_read_data;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          sdram_read, sdram_write, sdram_acknowledge;
    logic [DW-1:0] sdram_write_data, sdram_read_data;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .m0_address(m0_address), .m0_byte_enable(m0_byte_enable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_write_data(m0_write_data), .m0_ack(m0_ack),
        .m0_err(m0_err), .m0_read_data(m0_read_data),
        .m1_address(m1_address), .m1_byte_enable(m1_byte_enable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_write_data(m1_write_data), .m1_ack(m1_ack),
        .m1_err(m1_err), .m1_read_data(m1_read_data),
        .sdram_address(sdram_address), .sdram_byte_enable(sdram_byte_enable),
        .sdram_read(sdram_read), .sdram_write(sdram_write),
        .sdram_write_data(sdram_write_data), .sdram_acknowledge(sdram_acknowledge),
        .sdram_read_data(sdram_read_data)
    );

    int checks = 0;
    int passes = 0;

    // Requester-side record of each master's outstanding transaction.
    logic [AW-1:0] r_addr [2];
    logic [BW-1:0] r_be   [2];
    logic [DW-1:0] r_data [2];
    logic          r_wr   [2];
    logic          r_both [2];
    logic          pend   [2];
    int            last_served;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int m);
        logic rd, wr;
        wr = pend[m] && r_wr[m];
        rd = pend[m] && (!r_wr[m] || r_both[m]);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = r_addr[0];
            m0_byte_enable = r_be[0]; m0_write_data = r_data[0];
        end else begin
            m1_read = rd; m1_write = wr; m1_address = r_addr[1];
            m1_byte_enable = r_be[1]; m1_write_data = r_data[1];
        end
    endtask

    task automatic set_req(input int m, input logic wr, input logic both, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] d);
        r_wr[m] = wr; r_both[m] = both; r_addr[m] = a; r_be[m] = be; r_data[m] = d;
        pend[m] = 1'b1;
        drive_port(m);
    endtask

    task automatic clear_req(input int m);
        pend[m] = 1'b0;
        drive_port(m);
    endtask

    function automatic logic get_ack(input int m);
        return (m == 1) ? m1_ack : m0_ack;
    endfunction
    function automatic logic get_err(input int m);
        return (m == 1) ? m1_err : m0_err;
    endfunction
    function automatic logic [DW-1:0] get_rdata(input int m);
        return (m == 1) ? m1_read_data : m0_read_data;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, 64'({sdram_read, sdram_write}), 64'd0);
        chk({tag, "_addr"}, 64'(sdram_address), 64'd0);
        chk({tag, "_be"}, 64'(sdram_byte_enable), 64'd0);
        chk({tag, "_wdata"}, sdram_write_data, 64'd0);
        chk({tag, "_acks"}, 64'({m1_err, m1_ack, m0_err, m0_ack}), 64'd0);
        chk({tag, "_rdata"}, m0_read_data | m1_read_data, 64'd0);
    endtask

    task automatic reset_seq();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_served = 1;
    endtask

    // Granted master m is expected on the bridge next cycle; the bridge acks in its lat-th
    // strobe cycle, or never when lat == 0 (watchdog ends it after TO cycles).
    task automatic run_access(input int m, input int lat, input logic [DW-1:0] rdata);
        int n;
        n = (lat == 0) ? TO : lat;
        tick();
        for (int c = 1; c <= n; c++) begin
            chk("strobe_rd", 64'(sdram_read), 64'(!r_wr[m]));
            chk("strobe_wr", 64'(sdram_write), 64'(r_wr[m]));
            chk("addr", 64'(sdram_address), 64'(r_addr[m]));
            chk("be", 64'(sdram_byte_enable), 64'(r_wr[m] ? r_be[m] : 8'hFF));
            if (r_wr[m]) chk("wdata", sdram_write_data, r_data[m]);
            chk("early_ack", 64'({m1_ack, m0_ack}), 64'd0);
            sdram_acknowledge = (c == lat);
            sdram_read_data = rdata;
            tick();
        end
        sdram_acknowledge = 1'b0;
        chk("strobe_drop", 64'({sdram_read, sdram_write}), 64'd0);
        chk("ack", 64'(get_ack(m)), 64'd1);
        chk("ack_other", 64'(get_ack(1 - m)), 64'd0);
        chk("err", 64'(get_err(m)), 64'(lat == 0));
        chk("rdata", get_rdata(m), (lat == 0 || r_wr[m]) ? 64'd0 : rdata);
        last_served = m;
        clear_req(m);
        tick();
        chk("ack_pulse", 64'({m1_ack, m0_ack}), 64'd0);
    endtask

    initial begin
        int phase, cur_m, cnt, lat;
        int gap [2];
        logic snap [2];
        logic finishing, exp_err;
        logic [DW-1:0] exp_data;

        rst = 1'b1;
        sdram_acknowledge = 1'b0;
        sdram_read_data = '0;
        for (int m = 0; m < 2; m++) begin
            r_addr[m] = '0; r_be[m] = '0; r_data[m] = '0; r_wr[m] = 1'b0; r_both[m] = 1'b0;
            pend[m] = 1'b0;
            drive_port(m);
        end
        reset_seq();
        chk_all_zero("reset");

        // m0 read, bridge acks in the third strobe cycle
        set_req(0, 1'b0, 1'b0, 28'h000_0010, 8'h00, 64'd0);
        run_access(0, 3, 64'hDEAD_BEEF_0123_4567);

        // simultaneous contest after reset, then alternation
        reset_seq();
        set_req(0, 1'b0, 1'b0, 28'h000_0100, 8'h00, 64'd0);
        set_req(1, 1'b0, 1'b0, 28'h000_0200, 8'h00, 64'd0);
        run_access(0, 1, 64'h0000_0000_0000_0A0A);
        run_access(1, 2, 64'h0000_0000_0000_0B0B);
        set_req(0, 1'b0, 1'b0, 28'h000_0300, 8'h00, 64'd0);
        run_access(0, 1, 64'h0000_0000_0000_0C0C);
        set_req(0, 1'b1, 1'b0, 28'h000_0400, 8'h3C, 64'h5555_6666_7777_8888);
        set_req(1, 1'b0, 1'b0, 28'h000_0500, 8'h00, 64'd0);
        run_access(1, 1, 64'h0000_0000_0000_0D0D);
        run_access(0, 2, 64'h0000_0000_0000_0E0E);

        // m1 write at the top address
        set_req(1, 1'b1, 1'b0, 28'hFFF_FFFF, 8'h0F, 64'h1111_2222_3333_4444);
        run_access(1, 4, 64'hAAAA_BBBB_CCCC_DDDD);

        // watchdog: no ack, then a normal access
        set_req(0, 1'b0, 1'b0, 28'h012_3456, 8'h00, 64'd0);
        run_access(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        set_req(0, 1'b0, 1'b0, 28'h012_3457, 8'h00, 64'd0);
        run_access(0, 2, 64'h0102_0304_0506_0708);

        // reset while busy, then a late ack
        set_req(0, 1'b0, 1'b0, 28'h000_0055, 8'h00, 64'd0);
        tick();
        chk("busy_before_reset", 64'(sdram_read), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        rst = 1'b0;
        last_served = 1;
        clear_req(0);
        sdram_acknowledge = 1'b1;
        sdram_read_data = 64'h9999_9999_9999_9999;
        tick();
        chk_all_zero("late_ack");
        sdram_acknowledge = 1'b0;
        tick();
        chk_all_zero("late_ack2");

        // stray ack in idle and both strobes on m0
        set_req(0, 1'b1, 1'b1, 28'h000_0077, 8'hA5, 64'hCAFE_F00D_1234_5678);
        sdram_acknowledge = 1'b1;
        sdram_read_data = 64'h7777_7777_7777_7777;
        run_access(0, 2, 64'h3333_3333_3333_3333);

        // randomized traffic
        phase = 0; cur_m = 0; cnt = 0; lat = 1;
        finishing = 1'b0; exp_err = 1'b0; exp_data = '0;
        for (int m = 0; m < 2; m++) begin
            gap[m] = 0;
            snap[m] = pend[m];
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            // phase of the cycle now current: 0 idle, 1 access on the bridge, 2 response
            case (phase)
                0: if (snap[0] || snap[1]) begin
                    cur_m = (snap[0] && snap[1]) ? 1 - last_served : (snap[1] ? 1 : 0);
                    last_served = cur_m;
                    phase = 1;
                    cnt = 1;
                    lat = $urandom_range(1, TO + 3);
                end
                1: if (finishing) phase = 2; else cnt++;
                default: phase = 0;
            endcase

            chk("rnd_strobe", 64'(sdram_read | sdram_write), 64'(phase == 1));
            if (phase == 1) begin
                chk("rnd_op", 64'({sdram_write, sdram_read}), r_wr[cur_m] ? 64'd2 : 64'd1);
                chk("rnd_addr", 64'(sdram_address), 64'(r_addr[cur_m]));
                chk("rnd_be", 64'(sdram_byte_enable), 64'(r_wr[cur_m] ? r_be[cur_m] : 8'hFF));
                if (r_wr[cur_m]) chk("rnd_wdata", sdram_write_data, r_data[cur_m]);
            end
            if (phase == 2) begin
                chk("rnd_ack", 64'(get_ack(cur_m)), 64'd1);
                chk("rnd_ack_other", 64'(get_ack(1 - cur_m)), 64'd0);
                chk("rnd_err", 64'(get_err(cur_m)), 64'(exp_err));
                chk("rnd_rdata", get_rdata(cur_m), exp_data);
            end else begin
                chk("rnd_noack", 64'({m1_ack, m0_ack}), 64'd0);
            end

            sdram_acknowledge = 1'b0;
            finishing = 1'b0;
            if (phase == 1) begin
                if (cnt == lat) begin
                    sdram_acknowledge = 1'b1;
                    sdram_read_data = {$urandom, $urandom};
                    exp_err = 1'b0;
                    exp_data = r_wr[cur_m] ? 64'd0 : sdram_read_data;
                    finishing = 1'b1;
                end else if (cnt == TO) begin
                    exp_err = 1'b1;
                    exp_data = '0;
                    finishing = 1'b1;
                end
            end else if ($urandom_range(0, 4) == 0) begin
                sdram_acknowledge = 1'b1;
                sdram_read_data = {$urandom, $urandom};
            end

            for (int m = 0; m < 2; m++) begin
                if (phase == 2 && m == cur_m) begin
                    clear_req(m);
                    gap[m] = $urandom_range(1, 3);
                end else if (!pend[m]) begin
                    if (gap[m] > 0) gap[m]--;
                    else if ($urandom_range(0, 2) == 0)
                        set_req(m, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                                AW'($urandom), BW'($urandom), {$urandom, $urandom});
                end
                snap[m] = pend[m];
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
